// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage.
// Selects the writeback source and registers data, destination and write
// strobe toward the register file. Stalls while a load's data is outstanding
// and pulses load_err_out if that load times out. The registered outputs also
// serve as the forwarding source for the execute stage.
// Optional feature macro: LOAD_EXT_EN (sub-word load extraction and extension).
module wb_stage_pipe #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RF_ADDR_W    = 5,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 valid_in,
    input  logic                 flush_in,
    input  logic                 ALU_src_reg_in,
    input  logic [XLEN-1:0]      imm_reg_in,
    input  logic [XLEN-1:0]      rs2_reg_in,
    input  logic [2:0]           wb_mux_sel_reg_in,
    input  logic [XLEN-1:0]      ALU_result_in,
    input  logic [XLEN-1:0]      lu_output_in,
    input  logic                 lu_valid_in,
`ifdef LOAD_EXT_EN
    input  logic [1:0]           load_size_in,
    input  logic                 load_unsigned_in,
    input  logic [1:0]           addr_lsb_in,
`endif
    input  logic [XLEN-1:0]      iadder_out_reg_in,
    input  logic [XLEN-1:0]      csr_data_in,
    input  logic [XLEN-1:0]      pc_plus_4_reg_in,
    input  logic [RF_ADDR_W-1:0] rd_addr_in,
    input  logic                 rf_wr_en_in,
    output logic [XLEN-1:0]      alu_2nd_src_mux_out,
    output logic                 ready_out,
    output logic [XLEN-1:0]      wb_data_out,
    output logic [RF_ADDR_W-1:0] wb_rd_out,
    output logic                 wb_we_out,
    output logic                 load_err_out
);

    localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        SRC_ALU    = 3'b000,
        SRC_LU     = 3'b001,
        SRC_IMM    = 3'b010,
        SRC_IADDER = 3'b011,
        SRC_CSR    = 3'b100,
        SRC_PC4    = 3'b101
    } wb_src_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_LD
    } state_e;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   lu_data;
    logic [XLEN-1:0]   wb_sel_data;
    logic              load_stall;
    logic              wb_we_next;

    // ALU operand B select; never gated by stall or reset
    always_comb begin
        alu_2nd_src_mux_out = ALU_src_reg_in ? rs2_reg_in : imm_reg_in;
    end

`ifdef LOAD_EXT_EN
    logic [XLEN-1:0] lu_shifted;

    // Align the addressed byte/half to bit 0, then sign- or zero-extend
    always_comb begin
        lu_shifted = lu_output_in >> {addr_lsb_in, 3'b000};
        case (load_size_in)
            2'b00:   lu_data = {{(XLEN-8){~load_unsigned_in & lu_shifted[7]}},
                                lu_shifted[7:0]};
            2'b01:   lu_data = {{(XLEN-16){~load_unsigned_in & lu_shifted[15]}},
                                lu_shifted[15:0]};
            default: lu_data = lu_output_in;
        endcase
    end
`else
    assign lu_data = lu_output_in;
`endif

    // Writeback source mux; unused encodings fall back to the ALU result
    always_comb begin
        case (wb_src_e'(wb_mux_sel_reg_in))
            SRC_ALU:    wb_sel_data = ALU_result_in;
            SRC_LU:     wb_sel_data = lu_data;
            SRC_IMM:    wb_sel_data = imm_reg_in;
            SRC_IADDER: wb_sel_data = iadder_out_reg_in;
            SRC_CSR:    wb_sel_data = csr_data_in;
            SRC_PC4:    wb_sel_data = pc_plus_4_reg_in;
            default:    wb_sel_data = ALU_result_in;
        endcase
    end

    // Stall condition, write qualification and handshake toward upstream
    always_comb begin
        load_stall = valid_in & (wb_mux_sel_reg_in == SRC_LU) & ~lu_valid_in & ~flush_in;
        wb_we_next = rf_wr_en_in & (rd_addr_in != '0);
        ready_out  = ~reset_in & ~load_stall;
    end

    // Load-wait FSM with registered writeback and error outputs
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            wb_data_out  <= '0;
            wb_rd_out    <= '0;
            wb_we_out    <= 1'b0;
            load_err_out <= 1'b0;
        end else begin
            wb_we_out    <= 1'b0;
            load_err_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_stall) begin
                        state <= ST_WAIT_LD;
                        cnt   <= CNT_W'(1);
                    end else if (valid_in & ~flush_in) begin
                        wb_data_out <= wb_sel_data;
                        wb_rd_out   <= rd_addr_in;
                        wb_we_out   <= wb_we_next;
                    end
                end
                ST_WAIT_LD: begin
                    // flush beats load data, which beats the timeout
                    if (flush_in) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (lu_valid_in) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        wb_data_out <= wb_sel_data;
                        wb_rd_out   <= rd_addr_in;
                        wb_we_out   <= wb_we_next;
                    end else if (cnt == CNT_W'(LOAD_TIMEOUT)) begin
                        state        <= ST_IDLE;
                        cnt          <= '0;
                        load_err_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: directed bench for wb_stage_pipe with a writeback
// scoreboard; expected writes are queued when driven and popped on output.
module tb_wb_stage_pipe;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned RF_ADDR_W    = 5;
    localparam int unsigned LOAD_TIMEOUT = 15;

    localparam logic [31:0] ALU_V  = 32'hA1A1_0001;
    localparam logic [31:0] LU_V   = 32'h1111_2222;
    localparam logic [31:0] IMM_V  = 32'h0000_0ABC;
    localparam logic [31:0] IADD_V = 32'h0000_2004;
    localparam logic [31:0] CSR_V  = 32'hC5C5_0000;
    localparam logic [31:0] PC4_V  = 32'h0000_0104;
    localparam logic [31:0] RS2_V  = 32'h5A5A_0F0F;

    logic                 clk_in;
    logic                 reset_in;
    logic                 valid_in;
    logic                 flush_in;
    logic                 ALU_src_reg_in;
    logic [XLEN-1:0]      imm_reg_in;
    logic [XLEN-1:0]      rs2_reg_in;
    logic [2:0]           wb_mux_sel_reg_in;
    logic [XLEN-1:0]      ALU_result_in;
    logic [XLEN-1:0]      lu_output_in;
    logic                 lu_valid_in;
`ifdef LOAD_EXT_EN
    logic [1:0]           load_size_in;
    logic                 load_unsigned_in;
    logic [1:0]           addr_lsb_in;
`endif
    logic [XLEN-1:0]      iadder_out_reg_in;
    logic [XLEN-1:0]      csr_data_in;
    logic [XLEN-1:0]      pc_plus_4_reg_in;
    logic [RF_ADDR_W-1:0] rd_addr_in;
    logic                 rf_wr_en_in;
    logic [XLEN-1:0]      alu_2nd_src_mux_out;
    logic                 ready_out;
    logic [XLEN-1:0]      wb_data_out;
    logic [RF_ADDR_W-1:0] wb_rd_out;
    logic                 wb_we_out;
    logic                 load_err_out;

    wb_stage_pipe #(
        .XLEN         (XLEN),
        .RF_ADDR_W    (RF_ADDR_W),
        .LOAD_TIMEOUT (LOAD_TIMEOUT)
    ) dut (
        .clk_in              (clk_in),
        .reset_in            (reset_in),
        .valid_in            (valid_in),
        .flush_in            (flush_in),
        .ALU_src_reg_in      (ALU_src_reg_in),
        .imm_reg_in          (imm_reg_in),
        .rs2_reg_in          (rs2_reg_in),
        .wb_mux_sel_reg_in   (wb_mux_sel_reg_in),
        .ALU_result_in       (ALU_result_in),
        .lu_output_in        (lu_output_in),
        .lu_valid_in         (lu_valid_in),
`ifdef LOAD_EXT_EN
        .load_size_in        (load_size_in),
        .load_unsigned_in    (load_unsigned_in),
        .addr_lsb_in         (addr_lsb_in),
`endif
        .iadder_out_reg_in   (iadder_out_reg_in),
        .csr_data_in         (csr_data_in),
        .pc_plus_4_reg_in    (pc_plus_4_reg_in),
        .rd_addr_in          (rd_addr_in),
        .rf_wr_en_in         (rf_wr_en_in),
        .alu_2nd_src_mux_out (alu_2nd_src_mux_out),
        .ready_out           (ready_out),
        .wb_data_out         (wb_data_out),
        .wb_rd_out           (wb_rd_out),
        .wb_we_out           (wb_we_out),
        .load_err_out        (load_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_exp_t;

    wb_exp_t     sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_tab [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [4:0] rd);
        wb_exp_t e;
        e.data = data;
        e.rd   = rd;
        sb_q.push_back(e);
    endtask

    task automatic expect_write(input string tag);
        wb_exp_t e;
        chk({tag, "_we"}, 32'(wb_we_out), 32'd1);
        chk({tag, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, wb_data_out, e.data);
            chk({tag, "_rd"}, 32'(wb_rd_out), 32'(e.rd));
        end
    endtask

    task automatic expect_no_write(input string tag);
        chk({tag, "_we"}, 32'(wb_we_out), 32'd0);
        chk({tag, "_err"}, 32'(load_err_out), 32'd0);
    endtask

    task automatic drive_instr(input logic [2:0] sel, input logic [4:0] rd, input logic we);
        valid_in          = 1'b1;
        flush_in          = 1'b0;
        wb_mux_sel_reg_in = sel;
        rd_addr_in        = rd;
        rf_wr_en_in       = we;
    endtask

    task automatic bubble();
        valid_in    = 1'b0;
        flush_in    = 1'b0;
        lu_valid_in = 1'b0;
    endtask

    initial begin
        int          to_cycles;
        logic        to_seen;

        exp_tab = '{ALU_V, LU_V, IMM_V, IADD_V, CSR_V, PC4_V, ALU_V, ALU_V};

        // reset with arbitrary busy-looking inputs
        reset_in          = 1'b1;
        ALU_src_reg_in    = 1'b1;
        imm_reg_in        = IMM_V;
        rs2_reg_in        = RS2_V;
        ALU_result_in     = 32'hFFFF_FFFF;
        lu_output_in      = 32'h1234_5678;
        iadder_out_reg_in = IADD_V;
        csr_data_in       = CSR_V;
        pc_plus_4_reg_in  = PC4_V;
`ifdef LOAD_EXT_EN
        load_size_in      = 2'b10;
        load_unsigned_in  = 1'b0;
        addr_lsb_in       = 2'b00;
`endif
        drive_instr(3'b001, 5'd3, 1'b1);
        lu_valid_in = 1'b0;
        tick();
        tick();
        chk("rst_data", wb_data_out, 32'd0);
        chk("rst_rd", 32'(wb_rd_out), 32'd0);
        chk("rst_we", 32'(wb_we_out), 32'd0);
        chk("rst_err", 32'(load_err_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd0);

        // first instruction after reset release
        reset_in      = 1'b0;
        ALU_result_in = 32'h0000_1234;
        drive_instr(3'b000, 5'd5, 1'b1);
        #1;
        chk("rel_ready", 32'(ready_out), 32'd1);
        push_exp(32'h0000_1234, 5'd5);
        tick();
        expect_write("rel");
        bubble();
        tick();
        expect_no_write("rel_after");
        chk("rel_hold_data", wb_data_out, 32'h0000_1234);
        chk("rel_hold_rd", 32'(wb_rd_out), 32'd5);

        // back-to-back source sweep, operand B toggling each step
        ALU_result_in = ALU_V;
        lu_output_in  = LU_V;
        lu_valid_in   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_instr(3'(i), 5'(i + 1), 1'b1);
            ALU_src_reg_in = i[0];
            #1;
            chk($sformatf("opb_%0d", i), alu_2nd_src_mux_out, (i % 2 == 1) ? RS2_V : IMM_V);
            chk($sformatf("sweep_ready_%0d", i), 32'(ready_out), 32'd1);
            push_exp(exp_tab[i], 5'(i + 1));
            tick();
            expect_write($sformatf("sweep_%0d", i));
        end
        bubble();
        tick();
        expect_no_write("sweep_after");

        // load whose data arrives three cycles late
        lu_output_in = 32'hDEAD_BEEF;
        drive_instr(3'b001, 5'd7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("late_ready_%0d", k), 32'(ready_out), 32'd0);
            tick();
            expect_no_write($sformatf("late_wait_%0d", k));
        end
        lu_valid_in = 1'b1;
        #1;
        chk("late_ready_go", 32'(ready_out), 32'd1);
        push_exp(32'hDEAD_BEEF, 5'd7);
        tick();
        expect_write("late");
        bubble();
        tick();
        expect_no_write("late_after");

        // load that never completes: bounded wait for the timeout pulse
        drive_instr(3'b001, 5'd8, 1'b1);
        to_seen   = 1'b0;
        to_cycles = 0;
        for (int c = 1; c <= 40 && !to_seen; c++) begin
            tick();
            chk($sformatf("to_we_%0d", c), 32'(wb_we_out), 32'd0);
            if (load_err_out === 1'b1) begin
                to_seen   = 1'b1;
                to_cycles = c;
            end
        end
        chk("to_seen", 32'(to_seen), 32'd1);
        chk("to_cycles", 32'(to_cycles), 32'(LOAD_TIMEOUT + 1));
        bubble();
        #1;
        chk("to_ready", 32'(ready_out), 32'd1);
        tick();
        expect_no_write("to_after");

        // write to x0 is captured but never strobed
        ALU_result_in = 32'h0000_0055;
        drive_instr(3'b000, 5'd0, 1'b1);
        tick();
        chk("x0_we", 32'(wb_we_out), 32'd0);
        chk("x0_data", wb_data_out, 32'h0000_0055);
        chk("x0_rd", 32'(wb_rd_out), 32'd0);

        // flush while waiting for load data, then a normal instruction
        drive_instr(3'b001, 5'd9, 1'b1);
        lu_valid_in = 1'b0;
        tick();
        tick();
        expect_no_write("fl_wait");
        flush_in = 1'b1;
        #1;
        chk("fl_ready", 32'(ready_out), 32'd1);
        tick();
        expect_no_write("fl_kill");
        imm_reg_in = 32'h0000_0777;
        drive_instr(3'b010, 5'd10, 1'b1);
        push_exp(32'h0000_0777, 5'd10);
        tick();
        expect_write("fl_next");

        // flush of an idle-state instruction suppresses its capture
        ALU_result_in = 32'h0000_9999;
        drive_instr(3'b000, 5'd11, 1'b1);
        flush_in = 1'b1;
        tick();
        expect_no_write("fl_idle");
        chk("fl_idle_hold", wb_data_out, 32'h0000_0777);

        // reset during a load wait drops it silently
        drive_instr(3'b001, 5'd12, 1'b1);
        lu_valid_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b1;
        tick();
        expect_no_write("rw_rst");
        chk("rw_data", wb_data_out, 32'd0);
        chk("rw_rd", 32'(wb_rd_out), 32'd0);
        reset_in = 1'b0;
        bubble();
        tick();
        expect_no_write("rw_after");
        drive_instr(3'b101, 5'd13, 1'b1);
        push_exp(PC4_V, 5'd13);
        tick();
        expect_write("rw_next");

`ifdef LOAD_EXT_EN
        // sub-word load extraction and extension
        lu_output_in = 32'h0000_80FF;
        lu_valid_in  = 1'b1;
        drive_instr(3'b001, 5'd14, 1'b1);
        load_size_in = 2'b00; load_unsigned_in = 1'b0; addr_lsb_in = 2'b00;
        push_exp(32'hFFFF_FFFF, 5'd14);
        tick();
        expect_write("ext_b_s");
        load_size_in = 2'b01; load_unsigned_in = 1'b1; addr_lsb_in = 2'b00;
        push_exp(32'h0000_80FF, 5'd14);
        tick();
        expect_write("ext_h_u");
        load_size_in = 2'b01; load_unsigned_in = 1'b0; addr_lsb_in = 2'b00;
        push_exp(32'hFFFF_80FF, 5'd14);
        tick();
        expect_write("ext_h_s");
        load_size_in = 2'b00; load_unsigned_in = 1'b0; addr_lsb_in = 2'b01;
        push_exp(32'hFFFF_FF80, 5'd14);
        tick();
        expect_write("ext_b1_s");
        load_size_in = 2'b00; load_unsigned_in = 1'b1; addr_lsb_in = 2'b01;
        push_exp(32'h0000_0080, 5'd14);
        tick();
        expect_write("ext_b1_u");
        load_size_in = 2'b10; load_unsigned_in = 1'b0; addr_lsb_in = 2'b00;
`endif

        bubble();
        tick();
        expect_no_write("end");
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
